pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter controller for the single-cycle core.
- Owns the PC register and drives the branch-offset lookup table (6-bit index in, D-bit signed offset out, combinational).
- Sequences fetch from a start pulse through to program completion.
- Arbitrates between halt, stall, taken branch and sequential increment each cycle, and reports a retired-instruction count to the testbench/top level.

Parameters:
- D, 12: PC width; equals the lookup-table target width.
- CW, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE immediately.
- start  in  1  single-cycle pulse; begins execution at start_addr.
- start_addr  in  D  first instruction address, sampled on the start cycle.
- stall  in  1  hold PC this cycle.
- branch_en  in  1  taken relative branch in the current instruction.
- branch_sel  in  6  lookup-table index for the taken branch.
- lut_addr  out  6  drives the lookup-table address input.
- lut_target  in  D  signed offset returned combinationally by the lookup table.
- halt_req  in  1  current instruction is the program-end instruction.
- pc  out  D  current fetch address.
- fetch_valid  out  1  pc holds a live instruction address.
- done  out  1  program finished; held until the next start.
- instr_count  out  CW  instructions retired since the last start.

Behaviour:
- Reset (asynchronous, mid-operation included): state=IDLE, pc=0, fetch_valid=0, done=0, instr_count=0. The lookup-table address is unaffected (combinational).
- lut_addr = branch_sel, combinational, in every state; zero-cycle lookup. lut_target is consumed in the same cycle.
- FSM states:
  - IDLE: fetch_valid=0, done=0, pc holds. On start → RUN with pc<=start_addr and instr_count<=0.
  - RUN: fetch_valid=1. Next-PC priority, highest first:
    1. halt_req → DONE, pc holds.
    2. stall → pc holds, no retire.
    3. branch_en → pc <= pc + sign_extend(lut_target).
    4. otherwise → pc <= pc + 1.
  - DONE: fetch_valid=0, done=1, pc holds the halt address. On start → RUN exactly as from IDLE.
- halt_req && stall in the same cycle: halt wins; the halt instruction retires.
- Arithmetic is modulo 2^D: 0xFFF+1 → 0x000; 0x005 + (-17) → 0xFF4. No overflow flag.
- lut_target=0 (the table's default/hold entry) with branch_en: pc is unchanged and the instruction retires. This is a legal spin loop, not an error.
- start during RUN: ignored. start and halt_req in the same cycle in RUN: halt wins.
- instr_count increments by 1 on every RUN cycle without stall, including the halt cycle. It saturates at 2^CW-1 and clears only on start or reset.
- branch_en, stall and halt_req are don't-care outside RUN.
- Registered outputs: pc, fetch_valid, done, instr_count. lut_addr is the only combinational output.

Decomposition:
- Shared package (core_pkg):
  - typedef pc_t = logic[D-1:0]
  - enum seq_state_t {IDLE, RUN, DONE}
  - localparam LUT_AW=6
  - localparam PC_RESET='0
- One natural sub-module: pc_next_calc, a combinational next-PC mux with the halt/stall/branch/increment priority and the modulo add. It is reusable for a later pipelined fetch.
- The top instantiates the existing lookup table beside pc_sequencer. It is not nested inside.

Test Plan:
1. Reset then start with start_addr=0x010, no branches, 3 cycles → pc 0x010, 0x011, 0x012, 0x013; fetch_valid=1; instr_count=3.
2. At pc=0x020, branch_en=1, branch_sel=2 (lookup table returns -17) → next pc=0x00F; lut_addr=2 in the same cycle.
3. At pc=0xFFF, no branch → pc wraps to 0x000. At pc=0x003, branch_sel=4 (offset -28) → pc=0xFE7.
4. stall held 4 cycles at pc=0x030 → pc stays 0x030 and instr_count unchanged. Release with branch_sel=0 (offset +11) → pc=0x03B.
5. halt_req and stall together at pc=0x040 → DONE next cycle, done=1, fetch_valid=0, pc=0x040, instr_count+1. start in DONE with start_addr=0 → RUN, pc=0, instr_count=0.
6. Assert reset asynchronously mid-RUN, between clock edges → outputs reach reset values before the next edge. start during RUN is ignored (pc continues sequentially).

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the program-counter sequencer slice.
package core_pkg;

    localparam int PC_W   = 12;
    localparam int CNT_W  = 16;
    localparam int LUT_AW = 6;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t PC_RESET = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the core top level and the PC sequencer.
interface pc_sequencer_if
    import core_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int CW = CNT_W
);
    logic              start;
    logic [D-1:0]      start_addr;
    logic              stall;
    logic              branch_en;
    logic [LUT_AW-1:0] branch_sel;
    logic [LUT_AW-1:0] lut_addr;
    logic [D-1:0]      lut_target;
    logic              halt_req;
    logic [D-1:0]      pc;
    logic              fetch_valid;
    logic              done;
    logic [CW-1:0]     instr_count;

    modport master (
        output start, start_addr, stall, branch_en, branch_sel, lut_target, halt_req,
        input  lut_addr, pc, fetch_valid, done, instr_count
    );

    modport slave (
        input  start, start_addr, stall, branch_en, branch_sel, lut_target, halt_req,
        output lut_addr, pc, fetch_valid, done, instr_count
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: halt > stall > taken branch > increment, modulo 2^D.
module pc_next_calc #(
    parameter int D = 12
) (
    input  logic [D-1:0] pc,
    input  logic         halt,
    input  logic         stall,
    input  logic         branch,
    input  logic [D-1:0] offset,
    output logic [D-1:0] pc_next,
    output logic         retire
);

    // The offset already spans the full PC width, so a D-bit add is the sign-extended modulo add.
    always_comb begin
        pc_next = pc;
        retire  = 1'b0;
        if (halt) begin
            pc_next = pc;
            retire  = 1'b1;
        end else if (stall) begin
            pc_next = pc;
            retire  = 1'b0;
        end else if (branch) begin
            pc_next = pc + offset;
            retire  = 1'b1;
        end else begin
            pc_next = pc + {{(D-1){1'b0}}, 1'b1};
            retire  = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: start/run/done sequencing, PC register and retired-instruction count.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int CW = CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    seq_state_t    state_r;
    logic [D-1:0]  pc_r;
    logic          fetch_valid_r;
    logic          done_r;
    logic [CW-1:0] instr_count_r;
    logic [D-1:0]  pc_next_s;
    logic          retire_s;

    assign bus.lut_addr    = bus.branch_sel;
    assign bus.pc          = pc_r;
    assign bus.fetch_valid = fetch_valid_r;
    assign bus.done        = done_r;
    assign bus.instr_count = instr_count_r;

    pc_next_calc #(.D(D)) u_next (
        .pc      (pc_r),
        .halt    (bus.halt_req),
        .stall   (bus.stall),
        .branch  (bus.branch_en),
        .offset  (bus.lut_target),
        .pc_next (pc_next_s),
        .retire  (retire_s)
    );

    // Sequencer FSM with registered PC, status flags and saturating retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_r          <= D'(PC_RESET);
            fetch_valid_r <= 1'b0;
            done_r        <= 1'b0;
            instr_count_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_r       <= RUN;
                        pc_r          <= bus.start_addr;
                        fetch_valid_r <= 1'b1;
                        done_r        <= 1'b0;
                        instr_count_r <= {CW{1'b0}};
                    end else begin
                        state_r       <= state_r;
                        pc_r          <= pc_r;
                        fetch_valid_r <= 1'b0;
                        done_r        <= (state_r == DONE);
                        instr_count_r <= instr_count_r;
                    end
                end
                RUN: begin
                    pc_r <= pc_next_s;
                    if (retire_s && (instr_count_r != {CW{1'b1}})) begin
                        instr_count_r <= instr_count_r + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        instr_count_r <= instr_count_r;
                    end
                    // start is ignored here; halt is the only way out of RUN.
                    if (bus.halt_req) begin
                        state_r       <= DONE;
                        fetch_valid_r <= 1'b0;
                        done_r        <= 1'b1;
                    end else begin
                        state_r       <= RUN;
                        fetch_valid_r <= 1'b1;
                        done_r        <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    pc_r          <= D'(PC_RESET);
                    fetch_valid_r <= 1'b0;
                    done_r        <= 1'b0;
                    instr_count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
